// File: rtl/l1_spike_fifo_if.sv
// Interface bundling the L1 spike FIFO stimulus, handshake and status signals.
// slave  : the FIFO itself (consumes spikes/ready/clear, drives head and status).
// master : whatever drives the spike lines and consumes the FIFO head.
// Handshake: an entry transfers in a cycle where o_valid and i_ready are both 1;
// o_valid never depends on i_ready, and o_data stays stable while o_valid=1 and
// i_ready=0.
interface l1_spike_fifo_if #(
    parameter int p_n_neuron  = 2,
    parameter int p_ts_width  = 16,
    parameter int p_ptr_width = 3
);
    logic [p_n_neuron-1:0]            i_spike;
    logic                             i_ready;
    logic                             i_clr_ovf;
    logic                             o_valid;
    logic [p_ts_width+p_n_neuron-1:0] o_data;
    logic [p_ptr_width:0]             o_count;
    logic                             o_overflow;
    logic [7:0]                       o_drop_cnt;

    modport master (
        output i_spike,
        output i_ready,
        output i_clr_ovf,
        input  o_valid,
        input  o_data,
        input  o_count,
        input  o_overflow,
        input  o_drop_cnt
    );

    modport slave (
        input  i_spike,
        input  i_ready,
        input  i_clr_ovf,
        output o_valid,
        output o_data,
        output o_count,
        output o_overflow,
        output o_drop_cnt
    );
endinterface

// File: rtl/l1_spike_fifo.sv
// l1_spike_fifo: rising-edge detector on the L1 spike lines, timestamp tagging,
// first-word-fall-through FIFO with valid/ready readout, sticky overflow flag
// and saturating drop counter.
// Optional timestamp: define L1_SPIKE_FIFO_TIMESTAMP_EN to build the free-running
// counter and store {ts, mask}; without it only the mask is stored and the
// timestamp field of o_data reads as 0.
// Handshake: the head entry is removed in a cycle where o_valid and i_ready are
// both 1; o_valid does not depend on i_ready and o_data holds while stalled.
module l1_spike_fifo #(
    parameter int p_n_neuron  = 2,
    parameter int p_ts_width  = 16,
    parameter int p_depth     = 8,
    parameter int p_ptr_width = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    l1_spike_fifo_if.slave bus
);

    localparam int lp_data_w = p_ts_width + p_n_neuron;
`ifdef L1_SPIKE_FIFO_TIMESTAMP_EN
    localparam int lp_entry_w = p_ts_width + p_n_neuron;
`else
    localparam int lp_entry_w = p_n_neuron;
`endif
    localparam logic [p_ptr_width:0] lp_full_cnt = (p_ptr_width + 1)'(p_depth);

    logic [p_n_neuron-1:0]  r_spike_d;
    logic [p_n_neuron-1:0]  rise;
    logic [lp_entry_w-1:0]  r_mem [p_depth];
    logic [p_ptr_width-1:0] r_wr_ptr;
    logic [p_ptr_width-1:0] r_rd_ptr;
    logic [p_ptr_width:0]   r_count;
    logic                   r_overflow;
    logic [7:0]             r_drop_cnt;
    logic                   empty;
    logic                   full;
    logic                   push_req;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [lp_entry_w-1:0]  wr_entry;
    logic [lp_data_w-1:0]   head_data;

    // Edge detect and FIFO control decisions for the current cycle.
    always_comb begin
        rise     = bus.i_spike & ~r_spike_d;
        empty    = (r_count == '0);
        full     = (r_count == lp_full_cnt);
        push_req = |rise;
        // A pop needs a real head entry; a "pop" on an empty FIFO is ignored.
        pop      = ~empty & bus.i_ready;
        // When full, a simultaneous pop frees the slot the push lands in.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    // Previous spike levels; cleared on reset so a line held high across
    // reset release counts as a fresh rise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_spike_d <= '0;
        end else begin
            r_spike_d <= bus.i_spike;
        end
    end

`ifdef L1_SPIKE_FIFO_TIMESTAMP_EN
    logic [p_ts_width-1:0] r_ts;

    // Free-running timestamp, wraps naturally at 2^p_ts_width.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign wr_entry = {r_ts, rise};
`else
    assign wr_entry = rise;
`endif

    // Entry storage; contents need no reset because o_count gates visibility.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            r_mem[r_wr_ptr] <= wr_entry;
        end
    end

    // Pointers and occupancy; pointers wrap modulo p_depth, count tells full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (drop) begin
            r_overflow <= 1'b1;
            if (bus.i_clr_ovf) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (bus.i_clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    // Head entry, forced to zero when empty or while reset is asserted.
    always_comb begin
        head_data = '0;
        if (!i_rst && !empty) begin
`ifdef L1_SPIKE_FIFO_TIMESTAMP_EN
            head_data = r_mem[r_rd_ptr];
`else
            head_data = {{p_ts_width{1'b0}}, r_mem[r_rd_ptr]};
`endif
        end
    end

    // Outputs read as zero during the reset cycle itself.
    assign bus.o_valid    = ~i_rst & ~empty;
    assign bus.o_data     = head_data;
    assign bus.o_count    = i_rst ? '0 : r_count;
    assign bus.o_overflow = ~i_rst & r_overflow;
    assign bus.o_drop_cnt = i_rst ? 8'd0 : r_drop_cnt;

endmodule

// File: doc/l1_spike_fifo.md
Name: l1_spike_fifo

Overview:
- Sits directly downstream of the 2-neuron L1 layer and consumes its `o_spike_out[2:1]`.
- Detects rising edges of the spike lines and tags each spike cycle with a free-running timestamp.
- Buffers the tagged entries in a first-word-fall-through FIFO.
- Presents them to the next stage (L2 layer or host readout) over a valid/ready handshake.
- Keeps a sticky overflow flag and a saturating drop counter for spikes lost when the FIFO is full.

Parameters:
- p_n_neuron, 2, number of spike lines (neurons) from the L1 layer.
- p_ts_width, 16, timestamp counter width in bits.
- p_depth, 8, FIFO depth in entries; must be a power of 2 and at least 2.
- p_ptr_width, 3, log2(p_depth).

Ports:
- i_clk  input  1  clock; every register is clocked on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_spike  input  p_n_neuron  spike lines from the L1 layer; bit k = neuron k+1.
- i_ready  input  1  downstream can accept the entry on o_data this cycle.
- i_clr_ovf  input  1  one-cycle pulse; clears o_overflow and o_drop_cnt.
- o_valid  output  1  o_data holds a valid FIFO head entry.
- o_data  output  p_ts_width+p_n_neuron  head entry = {timestamp, spike mask}; the mask occupies the LSBs.
- o_count  output  p_ptr_width+1  number of entries currently stored, 0..p_depth.
- o_overflow  output  1  sticky; set when a spike entry was dropped.
- o_drop_cnt  output  8  number of dropped entries, saturating at 255.

Behaviour:
- Reset: one clock, i_rst=1, synchronous, active-high; i_rst dominates every other input.
  - Reset clears the timestamp counter, pointers, count, o_overflow, o_drop_cnt and the edge-detect register r_spike_d to 0.
  - All outputs are 0 during reset and in the first cycle after it.
  - Reset mid-operation discards all stored entries.
- Edge detect:
  - rise = i_spike & ~r_spike_d, evaluated every cycle; r_spike_d <= i_spike.
  - A spike line held high across reset release produces a rise in the first cycle after reset.
  - A line held high for multiple cycles yields exactly one rise.
- Timestamp: ts increments by 1 every non-reset cycle and wraps from 2^p_ts_width-1 to 0.
- Push:
  - If rise != 0, write the entry {ts, rise}, where ts is the counter value in the cycle the rise is detected.
  - Simultaneous rises on several neurons produce ONE entry with multiple mask bits set.
  - Latency: rise in cycle N makes the entry visible at the FIFO head (o_valid=1 if it was empty) in cycle N+1.
  - There is no same-cycle bypass.
- Pop: when o_valid & i_ready the head is removed. The next entry, if any, appears in the following cycle.
- Handshake hold: while o_valid=1 and i_ready=0, o_data stays stable.
- Empty: o_valid=0 and o_data=0. A push and a "pop" in the same cycle while empty is just a push.
- Full (o_count == p_depth):
  - Push with a simultaneous pop: the push is accepted and o_count stays at p_depth.
  - Push without a pop: the entry is dropped, o_overflow <= 1, and o_drop_cnt increments (it holds at 255).
- Clear: i_clr_ovf clears o_overflow and o_drop_cnt.
  - If a drop occurs in the same cycle as the clear, the drop wins: o_overflow=1 and o_drop_cnt=1.
- o_count updates each cycle: +1 on an accepted push only, -1 on a pop only, unchanged when both or neither occur.
- Pointers wrap modulo p_depth. Full and empty are distinguished by o_count.

Optional Feature:
- Macro: L1_SPIKE_FIFO_TIMESTAMP_EN.
- Defined: the timestamp counter is built and entries carry ts as specified above.
- Undefined: no counter is built and the FIFO stores only the mask bits.
  - o_data keeps its full width; the timestamp field is driven to constant 0.
  - All other behaviour is unchanged.

Test Plan:
- Reset then a single spike: release i_rst at cycle 0; pulse i_spike=2'b01 at cycle 5 (ts=5), i_ready=1.
  - Required: o_valid=1 at cycle 6 with o_data={16'd5, 2'b01}; o_valid=0 at cycle 7; o_count returns to 0.
- Simultaneous and held spikes: i_spike=2'b11 at cycle 10 and held high for 4 cycles.
  - Required: exactly one entry {16'd10, 2'b11}.
  - A later 2'b10 rise at cycle 20 gives {16'd20, 2'b10}.
- Fill and overflow: i_ready=0; 10 separate single-cycle spikes on bit 0.
  - Required: o_count=8, o_overflow=1, o_drop_cnt=2.
  - Draining with i_ready=1 yields the 8 entries in order with increasing timestamps.
- Full with a simultaneous push and pop: FIFO full, rise and i_ready=1 in the same cycle.
  - Required: o_count stays 8 and o_drop_cnt is unchanged.
- Clear collision: i_clr_ovf=1 in the same cycle as a drop.
  - Required: o_overflow=1 and o_drop_cnt=1. A clear alone then gives 0/0.
- Timestamp wrap and reset mid-run: run 65536+3 cycles and spike.
  - Required: ts=3 in the entry.
  - Assert i_rst with 4 entries stored: the next cycle has o_valid=0, o_count=0, and timestamps restart at 0.
